ray_generator: RTL and testbench

RAY_GENERATOR -- requirements
Module: ray_generator

---
 rtl/ray_generator.sv | 217 +++++++++++++++++++++
 tb/tb_ray_generator.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ray_generator.sv
// Ray generator: walks a width x height pixel grid and streams one camera ray per pixel with its buffer address.
// Optional backpressure counter enabled by defining RAY_GEN_STALL_COUNT_EN; vectors pack components as {z, y, x}.
module ray_generator #(
  parameter int POSITION_WIDTH = 16,
  parameter int ADDRESS_WIDTH  = 32
) (
  input  logic                        clock,
  input  logic                        resetN,
  input  logic                        start,
  input  logic                        flush,
  input  logic [ADDRESS_WIDTH-1:0]    frameAddress,
  input  logic [3*POSITION_WIDTH-1:0] cameraQ,
  input  logic [3*POSITION_WIDTH-1:0] cameraV,
  input  logic [3*POSITION_WIDTH-1:0] cameraX,
  input  logic [3*POSITION_WIDTH-1:0] cameraY,
  input  logic [11:0]                 width,
  input  logic [11:0]                 height,
  output logic                        rayValid,
  input  logic                        rayTaken,
  output logic [3*POSITION_WIDTH-1:0] rayOrigin,
  output logic [3*POSITION_WIDTH-1:0] rayDirection,
  output logic [ADDRESS_WIDTH-1:0]    pixelAddress,
  output logic                        rayLast,
  output logic                        ready,
  output logic                        busy,
  output logic                        interrupt,
  output logic [31:0]                 stallCount
);

  localparam int PW = POSITION_WIDTH;
  localparam int VW = 3 * POSITION_WIDTH;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Component-wise add; each lane wraps independently with no carry between lanes.
  function automatic logic [VW-1:0] vec_add(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] r;
    r = {VW{1'b0}};
    for (int i = 0; i < 3; i++) begin
      r[i*PW +: PW] = a[i*PW +: PW] + b[i*PW +: PW];
    end
    return r;
  endfunction

  state_t                   state_r, state_s;
  logic [11:0]              x_r, x_s, y_r, y_s;
  logic [11:0]              w_r, w_s, h_r, h_s;
  logic [VW-1:0]            q_r, q_s;
  logic [VW-1:0]            step_x_r, step_x_s, step_y_r, step_y_s;
  logic [VW-1:0]            row_base_r, row_base_s;
  logic [VW-1:0]            dir_r, dir_s;
  logic [ADDRESS_WIDTH-1:0] addr_r, addr_s;
  logic                     valid_r, valid_s;
  logic                     last_r, last_s;
  logic                     irq_r, irq_s;
  logic                     start_run_s;
  logic                     xfer_s;
  logic [11:0]              wm1_s, hm1_s;
  logic [VW-1:0]            next_row_s;

  assign xfer_s     = valid_r & rayTaken;
  assign wm1_s      = w_r - 12'd1;
  assign hm1_s      = h_r - 12'd1;
  assign next_row_s = vec_add(row_base_r, step_y_r);

  // Next-state and datapath update: start latch, pixel walk, frame end and flush.
  always_comb begin
    state_s     = state_r;
    x_s         = x_r;
    y_s         = y_r;
    w_s         = w_r;
    h_s         = h_r;
    q_s         = q_r;
    step_x_s    = step_x_r;
    step_y_s    = step_y_r;
    row_base_s  = row_base_r;
    dir_s       = dir_r;
    addr_s      = addr_r;
    valid_s     = valid_r;
    last_s      = last_r;
    irq_s       = 1'b0;
    start_run_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (flush) begin
          state_s = IDLE;
          valid_s = 1'b0;
          last_s  = 1'b0;
        end else if (start) begin
          if ((width == 12'd0) || (height == 12'd0)) begin
            irq_s = 1'b1;
          end else begin
            state_s     = RUN;
            start_run_s = 1'b1;
            x_s         = 12'd0;
            y_s         = 12'd0;
            w_s         = width;
            h_s         = height;
            q_s         = cameraQ;
            step_x_s    = cameraX;
            step_y_s    = cameraY;
            row_base_s  = cameraV;
            dir_s       = cameraV;
            addr_s      = frameAddress;
            valid_s     = 1'b1;
            last_s      = (width == 12'd1) && (height == 12'd1);
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (flush) begin
          state_s = IDLE;
          valid_s = 1'b0;
          last_s  = 1'b0;
        end else if (xfer_s) begin
          if (last_r) begin
            state_s = IDLE;
            valid_s = 1'b0;
            last_s  = 1'b0;
            irq_s   = 1'b1;
          end else if (x_r != wm1_s) begin
            x_s    = x_r + 12'd1;
            dir_s  = vec_add(dir_r, step_x_r);
            addr_s = addr_r + ADDRESS_WIDTH'(3'd4);
            last_s = ((x_r + 12'd1) == wm1_s) && (y_r == hm1_s);
          end else begin
            // Row wrap: the first pixel of the next row restarts from the advanced row base.
            x_s        = 12'd0;
            y_s        = y_r + 12'd1;
            row_base_s = next_row_s;
            dir_s      = next_row_s;
            addr_s     = addr_r + ADDRESS_WIDTH'(3'd4);
            last_s     = (wm1_s == 12'd0) && ((y_r + 12'd1) == hm1_s);
          end
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
        last_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_r    <= IDLE;
      x_r        <= 12'd0;
      y_r        <= 12'd0;
      w_r        <= 12'd0;
      h_r        <= 12'd0;
      q_r        <= {VW{1'b0}};
      step_x_r   <= {VW{1'b0}};
      step_y_r   <= {VW{1'b0}};
      row_base_r <= {VW{1'b0}};
      dir_r      <= {VW{1'b0}};
      addr_r     <= {ADDRESS_WIDTH{1'b0}};
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      x_r        <= x_s;
      y_r        <= y_s;
      w_r        <= w_s;
      h_r        <= h_s;
      q_r        <= q_s;
      step_x_r   <= step_x_s;
      step_y_r   <= step_y_s;
      row_base_r <= row_base_s;
      dir_r      <= dir_s;
      addr_r     <= addr_s;
      valid_r    <= valid_s;
      last_r     <= last_s;
      irq_r      <= irq_s;
    end
  end

`ifdef RAY_GEN_STALL_COUNT_EN
  logic [31:0] stall_r;

  // Counts cycles a beat is offered but not accepted; cleared when a frame starts.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      stall_r <= 32'd0;
    end else if (start_run_s) begin
      stall_r <= 32'd0;
    end else if (valid_r && !rayTaken) begin
      stall_r <= stall_r + 32'd1;
    end else begin
      stall_r <= stall_r;
    end
  end

  assign stallCount = stall_r;
`else
  assign stallCount = 32'd0;
`endif

  assign rayValid     = valid_r;
  assign rayLast      = last_r;
  assign rayOrigin    = q_r;
  assign rayDirection = dir_r;
  assign pixelAddress = addr_r;
  assign interrupt    = irq_r;
  assign ready        = (state_r == IDLE);
  assign busy         = (state_r == RUN);

endmodule

// File: tb/tb_ray_generator.sv
// Directed self-checking bench for ray_generator; expected values are hand-derived.
module tb_ray_generator;

  logic        clock = 1'b0;
  logic        resetN;
  logic        start, flush, rayTaken;
  logic [31:0] frameAddress;
  logic [47:0] cameraQ, cameraV, cameraX, cameraY;
  logic [11:0] width, height;
  logic        rayValid, rayLast, ready, busy, interrupt;
  logic [47:0] rayOrigin, rayDirection;
  logic [31:0] pixelAddress, stallCount;
  logic [31:0] exp_stall;

  int total = 0;
  int bad   = 0;

  ray_generator dut (
    .clock(clock), .resetN(resetN), .start(start), .flush(flush),
    .frameAddress(frameAddress), .cameraQ(cameraQ), .cameraV(cameraV),
    .cameraX(cameraX), .cameraY(cameraY), .width(width), .height(height),
    .rayValid(rayValid), .rayTaken(rayTaken), .rayOrigin(rayOrigin),
    .rayDirection(rayDirection), .pixelAddress(pixelAddress), .rayLast(rayLast),
    .ready(ready), .busy(busy), .interrupt(interrupt), .stallCount(stallCount)
  );

  always #5 clock = ~clock;

  function automatic logic [47:0] vec(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    return {z, y, x};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_frame(input logic [11:0] w, input logic [11:0] h, input logic [47:0] v,
                             input logic [47:0] x, input logic [47:0] y, input logic [31:0] fa);
    width = w; height = h; cameraQ = vec(16'd5, 16'd6, 16'd7);
    cameraV = v; cameraX = x; cameraY = y; frameAddress = fa;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_2x2(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_valid"}, rayValid, 1'b1);
      chk({tag, "_dir"}, rayDirection, vec(16'(i % 2), 16'(i / 2), 16'h0100));
      chk({tag, "_origin"}, rayOrigin, vec(16'd5, 16'd6, 16'd7));
      chk({tag, "_addr"}, pixelAddress, 32'h1000 + 32'(4 * i));
      chk({tag, "_last"}, rayLast, (i == 3) ? 1'b1 : 1'b0);
      start = (i == 1) ? 1'b1 : 1'b0;
      step();
    end
    start = 1'b0;
    chk({tag, "_end_valid"}, rayValid, 1'b0);
    chk({tag, "_end_irq"}, interrupt, 1'b1);
    chk({tag, "_end_ready"}, ready, 1'b1);
    step();
    chk({tag, "_irq_pulse"}, interrupt, 1'b0);
  endtask

  initial begin
    resetN = 1'b0; start = 1'b0; flush = 1'b0; rayTaken = 1'b1;
    frameAddress = 32'd0; cameraQ = 48'd0; cameraV = 48'd0; cameraX = 48'd0; cameraY = 48'd0;
    width = 12'd0; height = 12'd0;
    #12;
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", rayValid, 1'b0);
    chk("rst_irq", interrupt, 1'b0);
    chk("rst_stall", stallCount, 32'd0);
    chk("rst_dir", rayDirection, 48'd0);
    resetN = 1'b1;
    step();

    // 2x2 frame; inputs scrambled after the latch, start re-pulsed mid-frame
    start_frame(12'd2, 12'd2, vec(16'd0, 16'd0, 16'h0100), vec(16'd1, 16'd0, 16'd0),
                vec(16'd0, 16'd1, 16'd0), 32'h1000);
    chk("f1_busy", busy, 1'b1);
    cameraQ = vec(16'd9, 16'd9, 16'd9); cameraV = 48'd0; cameraX = vec(16'd3, 16'd3, 16'd3);
    frameAddress = 32'd0; width = 12'd7;
    run_2x2("f1");

    // backpressure on beat 2
    start_frame(12'd2, 12'd2, vec(16'd0, 16'd0, 16'h0100), vec(16'd1, 16'd0, 16'd0),
                vec(16'd0, 16'd1, 16'd0), 32'h1000);
    step();
    rayTaken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", rayValid, 1'b1);
      chk("bp_dir", rayDirection, vec(16'd1, 16'd0, 16'h0100));
      chk("bp_addr", pixelAddress, 32'h1004);
      chk("bp_last", rayLast, 1'b0);
    end
`ifdef RAY_GEN_STALL_COUNT_EN
    exp_stall = 32'd3;
`else
    exp_stall = 32'd0;
`endif
    chk("bp_stall", stallCount, exp_stall);
    rayTaken = 1'b1;
    step();
    chk("bp_beat3_dir", rayDirection, vec(16'd0, 16'd1, 16'h0100));
    chk("bp_beat3_addr", pixelAddress, 32'h1008);
    step();
    chk("bp_beat4_last", rayLast, 1'b1);
    step();
    chk("bp_end_irq", interrupt, 1'b1);
    chk("bp_stall_hold", stallCount, exp_stall);
    step();

    // zero-sized frame
    start_frame(12'd0, 12'd5, 48'd0, 48'd0, 48'd0, 32'h3000);
    chk("zero_valid", rayValid, 1'b0);
    chk("zero_irq", interrupt, 1'b1);
    chk("zero_ready", ready, 1'b1);
    step();
    chk("zero_irq_pulse", interrupt, 1'b0);
    chk("zero_valid2", rayValid, 1'b0);

    // flush overrides simultaneous start
    flush = 1'b1;
    start_frame(12'd2, 12'd2, vec(16'd0, 16'd0, 16'h0100), 48'd0, 48'd0, 32'h1000);
    flush = 1'b0;
    chk("fs_ready", ready, 1'b1);
    chk("fs_valid", rayValid, 1'b0);

    // 3x3 flushed after beat 2 transfers, then restart
    start_frame(12'd3, 12'd3, vec(16'd0, 16'd0, 16'h0100), vec(16'd1, 16'd0, 16'd0),
                vec(16'd0, 16'd1, 16'd0), 32'h2000);
    step();
    step();
    chk("fl_beat3_dir", rayDirection, vec(16'd2, 16'd0, 16'h0100));
    chk("fl_beat3_addr", pixelAddress, 32'h2008);
    rayTaken = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; rayTaken = 1'b1;
    chk("fl_valid", rayValid, 1'b0);
    chk("fl_irq", interrupt, 1'b0);
    chk("fl_ready", ready, 1'b1);
    step();
    chk("fl_irq2", interrupt, 1'b0);
    start_frame(12'd3, 12'd3, vec(16'd0, 16'd0, 16'h0100), vec(16'd1, 16'd0, 16'd0),
                vec(16'd0, 16'd1, 16'd0), 32'h2000);
    chk("fl_re_dir", rayDirection, vec(16'd0, 16'd0, 16'h0100));
    chk("fl_re_addr", pixelAddress, 32'h2000);
    chk("fl_re_busy", busy, 1'b1);
    rayTaken = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; rayTaken = 1'b1;
    chk("fl_re_ready", ready, 1'b1);

    // component wrap
    start_frame(12'd3, 12'd1, 48'd0, vec(16'h7FFF, 16'd0, 16'd0), 48'd0, 32'h0);
    chk("wrap_b1", rayDirection, vec(16'h0000, 16'd0, 16'd0));
    step();
    chk("wrap_b2", rayDirection, vec(16'h7FFF, 16'd0, 16'd0));
    chk("wrap_b2_last", rayLast, 1'b0);
    step();
    chk("wrap_b3", rayDirection, vec(16'hFFFE, 16'd0, 16'd0));
    chk("wrap_b3_last", rayLast, 1'b1);
    step();
    chk("wrap_irq", interrupt, 1'b1);
    step();

    // asynchronous reset mid-frame
    start_frame(12'd2, 12'd2, vec(16'd0, 16'd0, 16'h0100), vec(16'd1, 16'd0, 16'd0),
                vec(16'd0, 16'd1, 16'd0), 32'h1000);
    step();
    #2;
    resetN = 1'b0;
    #1;
    chk("ar_valid", rayValid, 1'b0);
    chk("ar_ready", ready, 1'b1);
    chk("ar_busy", busy, 1'b0);
    chk("ar_addr", pixelAddress, 32'd0);
    chk("ar_dir", rayDirection, 48'd0);
    resetN = 1'b1;
    step();
    chk("ar_irq", interrupt, 1'b0);
    chk("ar_idle_valid", rayValid, 1'b0);
    start_frame(12'd2, 12'd2, vec(16'd0, 16'd0, 16'h0100), vec(16'd1, 16'd0, 16'd0),
                vec(16'd0, 16'd1, 16'd0), 32'h1000);
    run_2x2("ar");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
